fifo_parammod: RTL and testbench
================================

# fifo_parammod

Parametrised synchronous FIFO for buffering between the SDRAM base modules and their control/function modules. It generalises the fixed 16×1024 save FIFO with configurable data width and depth, a fill count, programmable almost-full and almost-empty tags, and full-with-read pass-through. Show-ahead output: the head word is always presented on `oData`. It keeps the `iEn`/`oTag` handshake style used across the SDRAM modules.

## Interface
- `DW`, 16, data width in bits
- `AW`, 10, address width; depth = 2^AW words
- `AF_LVL`, 2^AW−4, almost-full threshold in words
- `AE_LVL`, 4, almost-empty threshold in words
- `CLOCK`  in  1  single clock, all logic on rising edge
- `RESET`  in  1  synchronous, active-low reset
- `iEn`  in  2  [1] write request, [0] read request
- `iData`  in  DW  write data
- `oData`  out  DW  head word (show-ahead)
- `oTag`  out  4  [3] almost full, [2] almost empty, [1] full, [0] empty
- `oCount`  out  AW+1  words currently stored, 0..2^AW
- `oErr`  out  2  [1] sticky overflow, [0] sticky underflow (see Configuration)

## Operation
- Storage: 2^AW × DW array, asynchronous read, not cleared by reset; `oData` is meaningful only while `oTag[0]`=0.
- Pointers `wp`, `rp` are AW+1 bits; the MSB is a wrap bit and index = low AW bits. Natural modulo-2^(AW+1) wrap.
- Read accepted (`rd_ok`) = `iEn[0]` & !empty. It advances `rp`.
- Write accepted (`wr_ok`) = `iEn[1]` & (!full | `rd_ok`). It stores `iData` at `wp[AW-1:0]` and advances `wp`.
- Full and both requests: both are accepted, and the count stays at 2^AW.
- Empty and both requests: only the write is accepted, and the count becomes 1.
- Rejected requests are dropped silently and leave no state change.
- `oCount` update: +1 on write-only accept, −1 on read-only accept, unchanged on both or neither accepted.
- Flags are decoded from the registered pointers and count:
  - empty = (`wp`==`rp`)
  - full = MSBs differ & low bits equal
  - almost empty = `oCount` ≤ AE_LVL
  - almost full = `oCount` ≥ AF_LVL
- Reset (`RESET`=0 at a rising edge): `wp`=`rp`=0, `oCount`=0, `oTag`=4'b0101, `oErr`=2'b00. Reset mid-operation discards all contents and has priority over any `iEn` in the same cycle.

## Timing
- Write latency: a word accepted at edge N is visible on `oData` after edge N if the FIFO was empty, and `oTag[0]` falls after edge N.
- Read: `oData` shows the next word right after the accepting edge; there is no extra read cycle.
- `oTag` and `oCount` change only on rising edges and reflect the state after that edge. No combinational path exists from `iEn` to `oTag` or `oCount`.
- `oData` is combinational from `rp` and the storage. A write to the head location when count=0 appears after the edge, never in the same cycle.
- Sustained one word per cycle in both directions at any fill level.

## Configuration
- `FIFO_ERRFLAG_EN` defined:
  - `oErr[1]` sets when `iEn[1]` & full & !`rd_ok`.
  - `oErr[0]` sets when `iEn[0]` & empty.
  - Both bits set on the edge after the violation, stay set until reset, and read as 0 after reset.
- `FIFO_ERRFLAG_EN` undefined: `oErr` is tied to 2'b00 and no error logic is synthesised. All other behaviour is identical.

## Test plan
All scenarios use DW=16, AW=4, AF_LVL=12, AE_LVL=2, with `FIFO_ERRFLAG_EN` defined.
- Reset with writes held high: `oTag`=4'b0101, `oCount`=0, `oErr`=0.
- Write 0x0001..0x0010 in consecutive cycles:
  - `oTag[2]` clears at count 3.
  - `oTag[3]` sets at count 12.
  - At count 16, `oTag`=4'b1010 and `oData`=0x0001.
- When full, write 0xBEEF alone: count stays 16, contents unchanged, `oErr`=2'b10. Then assert read+write 0x0011: count stays 16, `oData`=0x0002, and the tail entry holds 0x0011.
- Read 16 times: `oData` sequence is 0x0002..0x0010, 0x0011; the FIFO ends empty (`oTag`=4'b0101). One more read sets `oErr[0]` and leaves `rp` unchanged.
- Pointer wrap: run 40 write/read pairs with random data at count 5. Each read data equals the data written 5 accepts earlier, and `oCount` stays at 5.
- Assert `RESET` at count 7 with read+write both asserted: after the edge `oCount`=0, `oTag`=4'b0101, `oErr`=0.

Source files
------------

// File: rtl/fifo_parammod_if.sv
// Handshake/data bundle between fifo_parammod and its producer/consumer; master drives requests, slave is the FIFO.
interface fifo_parammod_if #(
   parameter int DW = 16,
   parameter int AW = 10
);
   logic [1:0]    iEn;
   logic [DW-1:0] iData;
   logic [DW-1:0] oData;
   logic [3:0]    oTag;
   logic [AW:0]   oCount;
   logic [1:0]    oErr;

   modport master (output iEn, iData, input oData, oTag, oCount, oErr);
   modport slave  (input iEn, iData, output oData, oTag, oCount, oErr);
endinterface

// File: rtl/fifo_parammod.sv
// Parametrised show-ahead synchronous FIFO with fill count, almost-full/empty tags and full-with-read pass-through.
// FIFO_ERRFLAG_EN enables sticky overflow/underflow flags on oErr; otherwise oErr is tied low.
module fifo_parammod #(
   parameter int DW     = 16,
   parameter int AW     = 10,
   parameter int AF_LVL = (1 << AW) - 4,
   parameter int AE_LVL = 4
) (
   input  logic           CLOCK,
   input  logic           RESET,
   fifo_parammod_if.slave bus
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] AF_THR = AF_LVL[AW:0];
   localparam logic [AW:0] AE_THR = AE_LVL[AW:0];

   logic [DW-1:0] mem [0:DEPTH-1];
   logic [AW:0]   wp;
   logic [AW:0]   rp;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          rdOk;
   logic          wrOk;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   // A read in the same cycle frees the slot, so a write to a full FIFO still goes through.
   assign rdOk  = bus.iEn[0] & ~empty;
   assign wrOk  = bus.iEn[1] & (~full | rdOk);

   // Storage is deliberately not reset; stale words are hidden by the empty tag.
   always_ff @(posedge CLOCK) begin
      if (RESET && wrOk) begin
         mem[wp[AW-1:0]] <= bus.iData;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wrOk) wp <= wp + 1'b1;
         if (rdOk) rp <= rp + 1'b1;
         case ({wrOk, rdOk})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.oData  = mem[rp[AW-1:0]];
   assign bus.oCount = count;
   assign bus.oTag   = {(count >= AF_THR), (count <= AE_THR), full, empty};

`ifdef FIFO_ERRFLAG_EN
   logic [1:0] err;

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         err <= 2'b00;
      end else begin
         if (bus.iEn[1] & full & ~rdOk) err[1] <= 1'b1;
         if (bus.iEn[0] & empty)        err[0] <= 1'b1;
      end
   end

   assign bus.oErr = err;
`else
   assign bus.oErr = 2'b00;
`endif

endmodule

// File: tb/tb_fifo_parammod.sv
// Self-checking bench for fifo_parammod: vector table, hand-written corner sequences and random traffic vs a queue model.
module tb_fifo_parammod;
   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int AF    = 12;
   localparam int AE    = 2;
   localparam int DEPTH = 16;
`ifdef FIFO_ERRFLAG_EN
   localparam bit ERRF = 1'b1;
`else
   localparam bit ERRF = 1'b0;
`endif

   logic CLOCK = 1'b0;
   logic RESET = 1'b0;

   fifo_parammod_if #(.DW(DW), .AW(AW)) bus ();

   fifo_parammod #(.DW(DW), .AW(AW), .AF_LVL(AF), .AE_LVL(AE)) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic [1:0]  en;
      logic [15:0] dat;
      int          cnt;
      logic [3:0]  tag;
      logic [15:0] head;
      logic [1:0]  err;
   } vec_t;

   vec_t          vt [18];
   logic [DW-1:0] mq [$];
   logic [1:0]    merr = 2'b00;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle, advance the queue model by the FIFO's acceptance rules, then settle past the edge.
   task automatic step(input logic rst, input logic [1:0] en, input logic [DW-1:0] d);
      bit rd;
      bit wr;
      RESET     = rst;
      bus.iEn   = en;
      bus.iData = d;
      @(posedge CLOCK);
      if (!rst) begin
         mq.delete();
         merr = 2'b00;
      end else begin
         rd = en[0] && (mq.size() > 0);
         wr = en[1] && ((mq.size() < DEPTH) || rd);
         if (en[1] && (mq.size() == DEPTH) && !rd) merr[1] = 1'b1;
         if (en[0] && (mq.size() == 0))            merr[0] = 1'b1;
         if (rd) void'(mq.pop_front());
         if (wr) mq.push_back(d);
      end
      #1;
   endtask

   task automatic chkModel(input string nm);
      int n;
      n = mq.size();
      chk({nm, " count"}, 32'(bus.oCount), 32'(n));
      chk({nm, " tag"}, 32'(bus.oTag), 32'({(n >= AF), (n <= AE), (n == DEPTH), (n == 0)}));
      chk({nm, " err"}, 32'(bus.oErr), ERRF ? 32'(merr) : 32'd0);
      if (n > 0) chk({nm, " data"}, 32'(bus.oData), 32'(mq[0]));
   endtask

   initial begin
      logic [15:0] expd;
      logic [1:0]  en;
      int          bias;

      bus.iEn   = 2'b00;
      bus.iData = '0;

      vt[0]  = '{2'b10, 16'h0001,  1, 4'b0100, 16'h0001, 2'b00};
      vt[1]  = '{2'b10, 16'h0002,  2, 4'b0100, 16'h0001, 2'b00};
      vt[2]  = '{2'b10, 16'h0003,  3, 4'b0000, 16'h0001, 2'b00};
      vt[3]  = '{2'b10, 16'h0004,  4, 4'b0000, 16'h0001, 2'b00};
      vt[4]  = '{2'b10, 16'h0005,  5, 4'b0000, 16'h0001, 2'b00};
      vt[5]  = '{2'b10, 16'h0006,  6, 4'b0000, 16'h0001, 2'b00};
      vt[6]  = '{2'b10, 16'h0007,  7, 4'b0000, 16'h0001, 2'b00};
      vt[7]  = '{2'b10, 16'h0008,  8, 4'b0000, 16'h0001, 2'b00};
      vt[8]  = '{2'b10, 16'h0009,  9, 4'b0000, 16'h0001, 2'b00};
      vt[9]  = '{2'b10, 16'h000A, 10, 4'b0000, 16'h0001, 2'b00};
      vt[10] = '{2'b10, 16'h000B, 11, 4'b0000, 16'h0001, 2'b00};
      vt[11] = '{2'b10, 16'h000C, 12, 4'b1000, 16'h0001, 2'b00};
      vt[12] = '{2'b10, 16'h000D, 13, 4'b1000, 16'h0001, 2'b00};
      vt[13] = '{2'b10, 16'h000E, 14, 4'b1000, 16'h0001, 2'b00};
      vt[14] = '{2'b10, 16'h000F, 15, 4'b1000, 16'h0001, 2'b00};
      vt[15] = '{2'b10, 16'h0010, 16, 4'b1010, 16'h0001, 2'b00};
      vt[16] = '{2'b10, 16'hBEEF, 16, 4'b1010, 16'h0001, 2'b10};
      vt[17] = '{2'b11, 16'h0011, 16, 4'b1010, 16'h0002, 2'b10};

      // Reset with both requests held high.
      step(1'b0, 2'b11, 16'hAAAA);
      step(1'b0, 2'b11, 16'h5555);
      chk("reset tag", 32'(bus.oTag), 32'h5);
      chk("reset count", 32'(bus.oCount), 32'd0);
      chk("reset err", 32'(bus.oErr), 32'd0);

      // Fill to full, overflow attempt, then full pass-through.
      for (int i = 0; i < 18; i++) begin
         step(1'b1, vt[i].en, vt[i].dat);
         chk($sformatf("vec%0d count", i), 32'(bus.oCount), 32'(vt[i].cnt));
         chk($sformatf("vec%0d tag", i), 32'(bus.oTag), 32'(vt[i].tag));
         chk($sformatf("vec%0d data", i), 32'(bus.oData), 32'(vt[i].head));
         chk($sformatf("vec%0d err", i), 32'(bus.oErr), ERRF ? 32'(vt[i].err) : 32'd0);
      end

      // Drain: head sequence 0x0002..0x0010 then the pass-through word 0x0011.
      for (int k = 0; k < 16; k++) begin
         expd = (k < 15) ? 16'(16'h0002 + k) : 16'h0011;
         chk($sformatf("drain%0d data", k), 32'(bus.oData), 32'(expd));
         step(1'b1, 2'b01, 16'h0000);
      end
      chk("drained tag", 32'(bus.oTag), 32'h5);
      chk("drained count", 32'(bus.oCount), 32'd0);

      // Underflow: flag sets, pointers must not move.
      step(1'b1, 2'b01, 16'h0000);
      chk("underflow err", 32'(bus.oErr), ERRF ? 32'h3 : 32'd0);
      chk("underflow count", 32'(bus.oCount), 32'd0);
      step(1'b1, 2'b10, 16'h1234);
      chk("post-underflow data", 32'(bus.oData), 32'h1234);
      chk("post-underflow count", 32'(bus.oCount), 32'd1);

      // Pointer wrap at a steady count of 5.
      for (int k = 0; k < 4; k++) step(1'b1, 2'b10, 16'($urandom));
      chkModel("prewrap");
      for (int k = 0; k < 40; k++) begin
         if (mq.size() > 0) begin
            chk($sformatf("wrap%0d data", k), 32'(bus.oData), 32'(mq[0]));
         end
         step(1'b1, 2'b11, 16'($urandom));
         chk($sformatf("wrap%0d count", k), 32'(bus.oCount), 32'd5);
      end
      chkModel("postwrap");

      // Reset at count 7 with both requests asserted.
      step(1'b1, 2'b10, 16'($urandom));
      step(1'b1, 2'b10, 16'($urandom));
      chk("pre-reset count", 32'(bus.oCount), 32'd7);
      step(1'b0, 2'b11, 16'hDEAD);
      chk("midreset count", 32'(bus.oCount), 32'd0);
      chk("midreset tag", 32'(bus.oTag), 32'h5);
      chk("midreset err", 32'(bus.oErr), 32'd0);

      // Random traffic, alternating write-heavy and read-heavy phases to reach both extremes.
      for (int k = 0; k < 600; k++) begin
         bias = ((k / 60) % 2 == 0) ? 75 : 25;
         en[1] = ($urandom_range(0, 99) < bias);
         en[0] = ($urandom_range(0, 99) < (100 - bias));
         step(($urandom_range(0, 199) != 0), en, 16'($urandom));
         chkModel($sformatf("rand%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
